// File: rtl/cla_div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
//   state_t         : divider control states (2-bit encoding)
//   DEFAULT_WIDTH   : default operand/quotient/remainder width
//   count_width()   : width of the iteration counter for a given operand width
package cla_div_pkg;

  // state | meaning
  // IDLE  | ready for a new operand pair
  // BUSY  | one quotient bit resolved per cycle
  // DONE  | result presented, waiting for consumer handshake
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DEFAULT_COUNT_W = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/cla_subtractor.sv
// Combinational N-bit subtractor i_a - i_b built as a carry-look-ahead adder
// on i_a and ~i_b with carry-in 1.
//   i_a    : minuend
//   i_b    : subtrahend
//   o_diff : i_a - i_b (modulo 2^N)
//   o_cout : carry out of the top bit; 1 means no borrow (i_a >= i_b)
module cla_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_cout
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_c;

  // Every carry is a flat sum of generate terms gated by the propagate chain
  // above them, so no carry depends on a lower computed carry.
  function automatic logic [N:0] lookahead(input logic [N-1:0] g,
                                           input logic [N-1:0] p,
                                           input logic         cin);
    logic [N:0] c;
    logic       term;
    logic       prop;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & cin);
    end
    return c;
  endfunction

  assign w_g    = i_a & ~i_b;
  assign w_p    = i_a ^ ~i_b;
  assign w_c    = lookahead(w_g, w_p, 1'b1);
  assign o_diff = w_p ^ w_c[N-1:0];
  assign o_cout = w_c[N];

endmodule

// File: rtl/cla_divider_seq.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, with
// valid/ready handshakes on both the operand and result sides.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (dividend, divisor)
//   out_valid, out_ready: result handshake (quotient, remainder, div_by_zero)
//   div_by_zero         : last accepted divisor was 0 (quotient all ones,
//                         remainder = dividend)
//
// state | meaning
// IDLE  | in_ready high, operands latched on in_valid
// BUSY  | WIDTH trial-subtraction cycles
// DONE  | out_valid high, held until out_ready
module cla_divider_seq
  import cla_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = count_width(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_cout;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_last;

  // Partial remainder shifted left with the next dividend bit; the extra
  // top bit keeps the shifted value from overflowing.
  assign w_shifted = (r_rem << 1) | {{WIDTH{1'b0}}, r_quo[WIDTH-1]};

  cla_subtractor #(.N(WIDTH + 1)) u_sub (
    .i_a    (w_shifted),
    .i_b    ({1'b0, r_dsr}),
    .o_diff (w_trial),
    .o_cout (w_cout)
  );

  assign w_rem_next = w_cout ? w_trial : w_shifted;
  assign w_quo_next = {r_quo[WIDTH-2:0], w_cout};
  assign w_last     = (r_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_state_next = (divisor == '0) ? DONE : BUSY;
      BUSY: if (w_last) w_state_next = DONE;
      DONE: if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem         <= '0;
      r_quo         <= '0;
      r_dsr         <= '0;
      r_count       <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_quo   <= dividend;
            r_dsr   <= divisor;
            r_rem   <= '0;
            r_count <= '0;
            if (divisor == '0) begin
              r_quotient    <= '1;
              r_remainder   <= dividend;
              r_div_by_zero <= 1'b1;
            end
          end
        end
        BUSY: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_quotient    <= w_quo_next;
            r_remainder   <= w_rem_next[WIDTH-1:0];
            r_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_cla_divider_seq.sv
module tb_cla_divider_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  cla_divider_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: latency and results derived from plain arithmetic.
  // phase 0 = waiting for operands, 1 = computing, 2 = result offered.
  int          m_phase = 0;
  int          m_left = 0;
  int          p_q, p_r, p_z;
  logic [31:0] m_q = 0;
  logic [31:0] m_r = 0;
  logic [31:0] m_z = 0;
  bit          started = 0;

  always @(posedge clk) begin
    started = 1;
    if (!rst_n) begin
      m_phase = 0;
      m_q = 0;
      m_r = 0;
      m_z = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          if (divisor == 0) begin
            p_q = (1 << W) - 1;
            p_r = int'(dividend);
            p_z = 1;
            m_left = 1;
          end else begin
            p_q = int'(dividend) / int'(divisor);
            p_r = int'(dividend) % int'(divisor);
            p_z = 0;
            m_left = W + 1;
          end
          m_left--;
          if (m_left == 0) begin
            m_q = p_q; m_r = p_r; m_z = p_z; m_phase = 2;
          end else begin
            m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_q = p_q; m_r = p_r; m_z = p_z; m_phase = 2;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("model_out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("model_quotient", 32'(quotient), m_q);
      chk("model_remainder", 32'(remainder), m_r);
      chk("model_div_by_zero", 32'(div_by_zero), m_z);
    end
  end

  task automatic do_op(input int a, input int b, input int hold,
                       input int eq, input int er, input int ez, input int elat);
    int n;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_in_ready", 32'(in_ready), 32'd1);
    dividend  = W'(a);
    divisor   = W'(b);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    n = 1;
    // Operands change and in_valid stays high while busy; both must be ignored.
    while (!out_valid && n < 50) begin
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'(elat));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_quotient", 32'(quotient), 32'(eq));
        chk("bp_remainder", 32'(remainder), 32'(er));
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("held_quotient", 32'(quotient), 32'(eq));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    do_op(13, 3, 0, 4, 1, 0, 5);
    do_op(15, 1, 0, 15, 0, 0, 5);
    do_op(3, 7, 0, 0, 3, 0, 5);
    do_op(5, 0, 0, 15, 5, 1, 1);
    do_op(10, 4, 6, 2, 2, 0, 5);
    do_op(15, 15, 0, 1, 0, 0, 5);
    do_op(0, 6, 0, 0, 0, 0, 5);
    do_op(14, 0, 2, 15, 14, 1, 1);
    do_op(12, 5, 0, 2, 2, 0, 5);

    // Reset during the second BUSY cycle discards the operation.
    dividend = 4'd9;
    divisor  = 4'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_quotient", 32'(quotient), 32'd0);
    chk("mid_rst_remainder", 32'(remainder), 32'd0);
    chk("mid_rst_div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    do_op(9, 2, 0, 4, 1, 0, 5);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cla_divider_seq.md
Name: cla_divider_seq

Overview:
- Iterative unsigned restoring divider: the inverse operation of the team's carry-look-ahead adder.
- Computes one quotient bit per cycle by trial subtraction. The subtraction is A + ~B + 1 through a CLA subtract stage with Cin = 1.
- Sits behind a valid/ready input handshake and a valid/ready output handshake, for use as an arithmetic coprocessor in the datapath.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset; one clock, reset sampled on the rising edge of clk
- in_valid  input  1  dividend/divisor are valid
- in_ready  output  1  block can accept a new operation
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  quotient/remainder/div_by_zero are valid
- out_ready  input  1  consumer accepts the result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  last accepted divisor was 0

Behaviour:
- Reset (rst_n low at a clock edge):
  - state goes to IDLE; in_ready=1, out_valid=0.
  - quotient, remainder, div_by_zero all 0; internal rem/quo/count registers 0.
  - Reset overrides everything, including mid-BUSY or DONE; any in-flight operation is discarded.
- States are IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch dividend into the quo shift register and divisor into the dsr register; clear the rem register (WIDTH+1 bits) and count.
  - If divisor==0, go to DONE with quotient = all ones, remainder = dividend, div_by_zero=1.
  - Otherwise go to BUSY.
- BUSY (in_ready=0), each cycle:
  - shifted = {rem[WIDTH-1:0], quo[WIDTH-1]}.
  - trial = shifted - {1'b0, dsr} via the CLA subtract stage.
  - If cout=1 (no borrow): rem <= trial and quo <= {quo[WIDTH-2:0], 1}.
  - Else: rem <= shifted and quo <= {quo[WIDTH-2:0], 0}.
  - count increments. After WIDTH BUSY cycles go to DONE, driving quotient=quo, remainder=rem[WIDTH-1:0], div_by_zero=0.
- Latency:
  - Accept edge plus WIDTH BUSY edges. out_valid rises WIDTH+1 edges after the accept edge (5 for WIDTH=4).
  - Divide-by-zero: out_valid rises 1 edge after accept.
- DONE:
  - out_valid=1, in_ready=0. Outputs are held stable while out_ready=0 (backpressure, unlimited).
  - On an edge with out_ready=1: go to IDLE, out_valid goes 0. Result outputs keep their last values.
  - New input can be accepted no earlier than the cycle after the result handshake. There is no same-cycle pass-through; throughput is 1 op per WIDTH+2 cycles.
- Inputs dividend/divisor are sampled only on the accept edge; changes during BUSY are ignored.
- in_valid asserted while in_ready=0 has no effect; the source must hold it.
- Width rules:
  - rem register is WIDTH+1 bits so the shifted partial remainder never overflows.
  - Quotient is always < 2^WIDTH; remainder is always < divisor (non-zero divisor).
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Package cla_div_pkg:
  - state enum type (IDLE, BUSY, DONE), 2-bit encoding
  - default WIDTH constant
  - count width constant, $clog2(WIDTH)+1
- Sub-module cla_subtractor:
  - WIDTH+1-bit combinational A - B, built as a carry-look-ahead adder on A and ~B with Cin=1.
  - Outputs diff and cout, where cout=1 means no borrow.
  - Instantiated once in cla_divider_seq.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
- dividend=13, divisor=3, out_ready=1 -> out_valid exactly 5 edges after accept; quotient=4, remainder=1, div_by_zero=0. Then in_ready=1 the next cycle.
- dividend=15, divisor=1 -> quotient=15, remainder=0. dividend=3, divisor=7 -> quotient=0, remainder=3.
- dividend=5, divisor=0 -> out_valid 1 edge after accept; quotient=15, remainder=5, div_by_zero=1.
- Backpressure: 10/4 with out_ready=0 for 6 cycles -> out_valid held, quotient=2, remainder=2 stable, in_ready=0. out_ready=1 -> out_valid drops next edge.
- Reset mid-operation: accept 9/2, assert rst_n=0 on the 2nd BUSY cycle -> next edge IDLE with outputs cleared. A subsequent 9/2 then yields quotient=4, remainder=1.
